// File: rtl/zoom_if.sv
// zoom_if: command/engine/display signals between button logic, engine and zoom_controller
// master: drives zoom_in/zoom_out/engine_done/frame_sync, observes controller outputs
// slave : zoom_controller side
interface zoom_if;
  logic       zoom_in;
  logic       zoom_out;
  logic       engine_done;
  logic       frame_sync;
  logic [2:0] zoom_level;
  logic       engine_enable;
  logic       busy;
  logic       buf_sel;
  logic       swap_pulse;
  logic       limit_hit;
  logic       timeout_err;
  modport master (
    output zoom_in, zoom_out, engine_done, frame_sync,
    input  zoom_level, engine_enable, busy, buf_sel, swap_pulse, limit_hit, timeout_err
  );
  modport slave (
    input  zoom_in, zoom_out, engine_done, frame_sync,
    output zoom_level, engine_enable, busy, buf_sel, swap_pulse, limit_hit, timeout_err
  );
endinterface

// File: rtl/zoom_controller.sv
// zoom_controller: sequences zoom level changes, engine restarts and frame-synced buffer swaps
// clk, reset (async, active-high); zif.slave carries button pulses, engine handshake,
// frame_sync and the registered outputs (level, enable, busy, buf_sel, pulses, watchdog flag)
module zoom_controller #(
  parameter int MIN_LEVEL      = 0,
  parameter int MAX_LEVEL      = 4,
  parameter int DEFAULT_LEVEL  = 2,
  parameter int TIMEOUT_CYCLES = 307216,
  parameter int TW             = 19
) (
  input logic   clk,
  input logic   reset,
  zoom_if.slave zif
);
  typedef enum logic [2:0] {INIT, IDLE, LOAD, RUN, SWAP} state_t;
  state_t state, state_n;
  logic [2:0] level_n, prev, prev_n;
  logic [TW-1:0] wd, wd_n;
  logic en_n, busy_n, buf_n, lim_n, terr_n, pv, pv_n, pd, pd_n, tog, tog_n;
  logic single, cmd_up;
  assign single = zif.zoom_in ^ zif.zoom_out;
  // pending (pd = direction, 1 = up) takes priority over live buttons in IDLE
  assign cmd_up = pv ? pd : zif.zoom_in;
  always_comb begin
    state_n = state;
    level_n = zif.zoom_level;
    prev_n  = prev;
    wd_n    = wd;
    en_n    = zif.engine_enable;
    busy_n  = zif.busy;
    buf_n   = zif.buf_sel;
    terr_n  = zif.timeout_err;
    lim_n   = 1'b0;
    tog_n   = 1'b0;
    pv_n    = pv;
    pd_n    = pd;
    if (state != IDLE && single) begin
      pv_n = 1'b1;
      pd_n = zif.zoom_in;
    end
    case (state)
      INIT: begin
        state_n = LOAD;
        prev_n  = 3'(DEFAULT_LEVEL);
        busy_n  = 1'b1;
      end
      IDLE: begin
        // consuming pending frees the slot for a command arriving this same cycle
        if (pv) begin
          pv_n = single;
          pd_n = single ? zif.zoom_in : pd;
        end
        if (pv || single) begin
          if (cmd_up ? zif.zoom_level == 3'(MAX_LEVEL) : zif.zoom_level == 3'(MIN_LEVEL))
            lim_n = 1'b1;
          else begin
            prev_n  = zif.zoom_level;
            level_n = cmd_up ? zif.zoom_level + 3'd1 : zif.zoom_level - 3'd1;
            state_n = LOAD;
            busy_n  = 1'b1;
          end
        end
      end
      LOAD: begin
        state_n = RUN;
        en_n    = 1'b1;
        wd_n    = '0;
      end
      RUN: begin
        wd_n = wd + 1'b1;
        if (zif.engine_done) begin
          state_n = SWAP;
          en_n    = 1'b0;
          terr_n  = 1'b0;
        end else if (wd == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          en_n    = 1'b0;
          level_n = prev;
          terr_n  = 1'b1;
          busy_n  = 1'b0;
        end
      end
      SWAP: begin
        if (zif.frame_sync) begin
          state_n = IDLE;
          buf_n   = ~zif.buf_sel;
          tog_n   = 1'b1;
          busy_n  = 1'b0;
        end
      end
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= INIT;
      zif.zoom_level    <= 3'(DEFAULT_LEVEL);
      prev              <= 3'(DEFAULT_LEVEL);
      wd                <= '0;
      zif.engine_enable <= 1'b0;
      zif.busy          <= 1'b1;
      zif.buf_sel       <= 1'b0;
      zif.swap_pulse    <= 1'b0;
      zif.limit_hit     <= 1'b0;
      zif.timeout_err   <= 1'b0;
      pv                <= 1'b0;
      pd                <= 1'b0;
      tog               <= 1'b0;
    end else begin
      state             <= state_n;
      zif.zoom_level    <= level_n;
      prev              <= prev_n;
      wd                <= wd_n;
      zif.engine_enable <= en_n;
      zif.busy          <= busy_n;
      zif.buf_sel       <= buf_n;
      zif.swap_pulse    <= tog;
      zif.limit_hit     <= lim_n;
      zif.timeout_err   <= terr_n;
      pv                <= pv_n;
      pd                <= pd_n;
      tog               <= tog_n;
    end
  end
endmodule

// File: tb/tb_zoom_controller.sv
// tb_zoom_controller: directed checks of zoom_controller (default watchdog and a short-watchdog copy)
module tb_zoom_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int n_swap = 0;
  int w_swap = 0;
  logic exp_buf = 1'b0;
  int s0;
  zoom_if m ();
  zoom_if w ();
  zoom_controller u_dut (.clk(clk), .reset(reset), .zif(m.slave));
  zoom_controller #(.TIMEOUT_CYCLES(50)) u_wd (.clk(clk), .reset(reset), .zif(w.slave));
  always #5 clk = ~clk;
  always @(posedge clk) if (m.swap_pulse) n_swap++;
  always @(posedge clk) if (w.swap_pulse) w_swap++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic render(input bit up, input logic [2:0] lvl);
    if (up) m.zoom_in = 1'b1; else m.zoom_out = 1'b1;
    tick(1);
    m.zoom_in = 1'b0;
    m.zoom_out = 1'b0;
    chk("load_en", m.engine_enable, 0);
    chk("load_lvl", m.zoom_level, lvl);
    chk("load_busy", m.busy, 1);
    tick(1);
    chk("run_en", m.engine_enable, 1);
    tick(3);
    m.engine_done = 1'b1;
    tick(1);
    m.engine_done = 1'b0;
    chk("done_en", m.engine_enable, 0);
    tick(2);
    m.frame_sync = 1'b1;
    tick(1);
    m.frame_sync = 1'b0;
    exp_buf = ~exp_buf;
    chk("swap_buf", m.buf_sel, exp_buf);
    chk("swap_busy", m.busy, 0);
    tick(1);
  endtask
  initial begin
    {m.zoom_in, m.zoom_out, m.engine_done, m.frame_sync} = '0;
    {w.zoom_in, w.zoom_out, w.engine_done, w.frame_sync} = '0;
    tick(2);
    chk("rst_lvl", m.zoom_level, 2);
    chk("rst_en", m.engine_enable, 0);
    chk("rst_busy", m.busy, 1);
    chk("rst_buf", m.buf_sel, 0);
    chk("rst_flags", {m.swap_pulse, m.limit_hit, m.timeout_err}, 0);
    reset = 1'b0;
    // INIT render
    tick(1);
    chk("init_load_en", m.engine_enable, 0);
    chk("init_lvl", m.zoom_level, 2);
    tick(1);
    chk("init_en", m.engine_enable, 1);
    tick(99);
    chk("init_en_hold", m.engine_enable, 1);
    m.engine_done = 1'b1;
    tick(1);
    m.engine_done = 1'b0;
    chk("init_done_en", m.engine_enable, 0);
    chk("init_swap_busy", m.busy, 1);
    tick(190);
    chk("init_wait_buf", m.buf_sel, 0);
    m.frame_sync = 1'b1;
    tick(1);
    m.frame_sync = 1'b0;
    exp_buf = 1'b1;
    chk("init_buf", m.buf_sel, 1);
    chk("init_busy", m.busy, 0);
    chk("init_sp0", m.swap_pulse, 0);
    tick(1);
    chk("init_sp1", m.swap_pulse, 1);
    tick(1);
    chk("init_sp2", m.swap_pulse, 0);
    // zoom_in, frame_sync on the same cycle as done is ignored
    m.zoom_in = 1'b1;
    tick(1);
    m.zoom_in = 1'b0;
    chk("zi_load_en", m.engine_enable, 0);
    chk("zi_lvl", m.zoom_level, 3);
    tick(1);
    chk("zi_en", m.engine_enable, 1);
    tick(10);
    m.engine_done = 1'b1;
    m.frame_sync = 1'b1;
    tick(1);
    m.engine_done = 1'b0;
    m.frame_sync = 1'b0;
    chk("zi_entry_sync_buf", m.buf_sel, 1);
    chk("zi_entry_sync_busy", m.busy, 1);
    tick(3);
    m.frame_sync = 1'b1;
    tick(1);
    m.frame_sync = 1'b0;
    exp_buf = 1'b0;
    chk("zi_buf", m.buf_sel, 0);
    chk("zi_busy", m.busy, 0);
    tick(1);
    // boundaries
    render(1, 4);
    m.zoom_in = 1'b1;
    tick(1);
    m.zoom_in = 1'b0;
    chk("max_lim", m.limit_hit, 1);
    chk("max_lvl", m.zoom_level, 4);
    chk("max_busy", m.busy, 0);
    tick(1);
    chk("max_lim_off", m.limit_hit, 0);
    render(0, 3);
    render(0, 2);
    render(0, 1);
    render(0, 0);
    m.zoom_out = 1'b1;
    tick(1);
    m.zoom_out = 1'b0;
    chk("min_lim", m.limit_hit, 1);
    chk("min_lvl", m.zoom_level, 0);
    chk("min_busy", m.busy, 0);
    tick(1);
    chk("min_lim_off", m.limit_hit, 0);
    render(1, 1);
    render(1, 2);
    m.zoom_in = 1'b1;
    m.zoom_out = 1'b1;
    tick(1);
    m.zoom_in = 1'b0;
    m.zoom_out = 1'b0;
    chk("both_busy", m.busy, 0);
    chk("both_lim", m.limit_hit, 0);
    chk("both_lvl", m.zoom_level, 2);
    // pending: last single command wins, in+out together ignored
    tick(3);
    s0 = n_swap;
    m.zoom_in = 1'b1;
    tick(1);
    m.zoom_in = 1'b0;
    chk("pend_lvl", m.zoom_level, 3);
    tick(3);
    m.zoom_in = 1'b1;
    tick(1);
    m.zoom_in = 1'b0;
    tick(2);
    m.zoom_out = 1'b1;
    tick(1);
    m.zoom_in = 1'b1;
    tick(1);
    m.zoom_in = 1'b0;
    m.zoom_out = 1'b0;
    m.engine_done = 1'b1;
    tick(1);
    m.engine_done = 1'b0;
    tick(2);
    m.frame_sync = 1'b1;
    tick(1);
    m.frame_sync = 1'b0;
    exp_buf = ~exp_buf;
    chk("pend_buf1", m.buf_sel, exp_buf);
    chk("pend_idle", m.busy, 0);
    tick(1);
    chk("pend_load_busy", m.busy, 1);
    chk("pend_load_lvl", m.zoom_level, 2);
    chk("pend_load_en", m.engine_enable, 0);
    tick(1);
    chk("pend_en", m.engine_enable, 1);
    m.engine_done = 1'b1;
    tick(1);
    m.engine_done = 1'b0;
    tick(2);
    m.frame_sync = 1'b1;
    tick(1);
    m.frame_sync = 1'b0;
    exp_buf = ~exp_buf;
    chk("pend_buf2", m.buf_sel, exp_buf);
    tick(5);
    chk("pend_final_busy", m.busy, 0);
    chk("pend_final_lvl", m.zoom_level, 2);
    chk("pend_renders", n_swap - s0, 2);
    // watchdog copy: INIT render timed out long ago
    chk("wd_init_terr", w.timeout_err, 1);
    chk("wd_init_lvl", w.zoom_level, 2);
    chk("wd_init_buf", w.buf_sel, 0);
    chk("wd_init_busy", w.busy, 0);
    chk("wd_init_swaps", w_swap, 0);
    w.zoom_in = 1'b1;
    tick(1);
    w.zoom_in = 1'b0;
    tick(6);
    w.engine_done = 1'b1;
    tick(1);
    w.engine_done = 1'b0;
    chk("wd_clear_terr", w.timeout_err, 0);
    tick(2);
    w.frame_sync = 1'b1;
    tick(1);
    w.frame_sync = 1'b0;
    chk("wd_ok_buf", w.buf_sel, 1);
    chk("wd_ok_lvl", w.zoom_level, 3);
    tick(3);
    s0 = w_swap;
    w.zoom_in = 1'b1;
    tick(1);
    w.zoom_in = 1'b0;
    chk("wd_load_lvl", w.zoom_level, 4);
    tick(1);
    chk("wd_en", w.engine_enable, 1);
    tick(49);
    chk("wd_en_last", w.engine_enable, 1);
    chk("wd_busy_last", w.busy, 1);
    tick(1);
    chk("wd_to_en", w.engine_enable, 0);
    chk("wd_to_lvl", w.zoom_level, 3);
    chk("wd_to_terr", w.timeout_err, 1);
    chk("wd_to_busy", w.busy, 0);
    tick(3);
    w.frame_sync = 1'b1;
    tick(1);
    w.frame_sync = 1'b0;
    tick(3);
    chk("wd_to_buf", w.buf_sel, 1);
    chk("wd_to_swaps", w_swap - s0, 0);
    // asynchronous reset mid-RUN
    m.zoom_out = 1'b1;
    tick(1);
    m.zoom_out = 1'b0;
    tick(5);
    chk("mid_en", m.engine_enable, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_lvl", m.zoom_level, 2);
    chk("arst_en", m.engine_enable, 0);
    chk("arst_busy", m.busy, 1);
    chk("arst_buf", m.buf_sel, 0);
    chk("arst_flags", {m.swap_pulse, m.limit_hit, m.timeout_err}, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_buf = 1'b0;
    tick(1);
    chk("re_load_en", m.engine_enable, 0);
    chk("re_lvl", m.zoom_level, 2);
    tick(1);
    chk("re_en", m.engine_enable, 1);
    m.engine_done = 1'b1;
    tick(1);
    m.engine_done = 1'b0;
    tick(2);
    m.frame_sync = 1'b1;
    tick(1);
    m.frame_sync = 1'b0;
    chk("re_buf", m.buf_sel, 1);
    chk("re_busy", m.busy, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
